// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative digit-serial multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-bit slices in a WIDTH-bit multiplier operand.
  function automatic int digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational WIDTH x DIGIT unsigned multiplier; one partial product per cycle.
module mult_digit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       i_a,
  input  logic [DIGIT-1:0]       i_d,
  output logic [WIDTH+DIGIT-1:0] o_prod
);

  assign o_prod = (WIDTH+DIGIT)'(i_a) * (WIDTH+DIGIT)'(i_d);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative multiplier consuming DIGIT bits of b per cycle, valid/ready on both sides.
// Optional signed mode is compiled in when SIGNED_EN is defined.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N     = digits(WIDTH, DIGIT);
  localparam int CNT_W = $clog2(N) + 1;
  localparam int ACC_W = 2 * WIDTH;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_multiplier: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [ACC_W-1:0]   r_product;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_last;
  int                 w_shamt;
  logic [DIGIT-1:0]   w_digit;
  logic [WIDTH+DIGIT-1:0] w_dprod;
  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W-1:0]   w_result;
  logic [WIDTH-1:0]   w_a_in;
  logic [WIDTH-1:0]   w_b_in;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_count == CNT_W'(N - 1));
  assign w_shamt  = int'(r_count) * DIGIT;
  assign w_digit  = DIGIT'(r_b >> w_shamt);

  mult_digit #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a    (r_a),
    .i_d    (w_digit),
    .o_prod (w_dprod)
  );

  assign w_acc_next = r_acc + (ACC_W'(w_dprod) << w_shamt);

`ifdef SIGNED_EN
  logic r_neg;
  logic w_neg_in;

  // Magnitudes are multiplied unsigned; 0x80..0 maps to its unsigned value.
  assign w_a_in   = (op_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_in   = (op_signed && b[WIDTH-1]) ? -b : b;
  assign w_neg_in = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_result = r_neg ? -w_acc_next : w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg_in;
    end
  end
`else
  assign w_a_in   = a;
  assign w_b_in   = b;
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        BUSY: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CNT_W'(1);
          // Product is only ever updated on the way into DONE.
          if (w_last) begin
            r_product   <= w_result;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign product   = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=16, DIGIT=4) plus DIGIT sweep instances.
`timescale 1ns/1ps
module tb_seq_multiplier;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
`ifdef SIGNED_EN
  logic           op_signed = 1'b0;
`endif
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] product;

  logic [3:0]     sw_valid;
  logic [3:0]     sw_ready;
  logic [3:0]     sw_busy;
  logic [2*W-1:0] sw_prod [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SIGNED_EN
    .op_signed (op_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int DG = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
    seq_multiplier #(.WIDTH(W), .DIGIT(DG)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (sw_ready[gi]),
      .a         (a),
      .b         (b),
`ifdef SIGNED_EN
      .op_signed (op_signed),
`endif
      .out_valid (sw_valid[gi]),
      .out_ready (out_ready),
      .product   (sw_prod[gi]),
      .busy      (sw_busy[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic sgn);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    a = ai;
    b = bi;
`ifdef SIGNED_EN
    op_signed = sgn;
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef SIGNED_EN
    op_signed = 1'b0;
`endif
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic sgn, input logic [2*W-1:0] exp);
    int cyc;
    start_op(ai, bi, sgn);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'd4);
    check({tag, "_prod"}, 64'(product), 64'(exp));
    release_out();
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
    $display("[TB] op %s a=%h b=%h product=%h", tag, ai, bi, product);
  endtask

  initial begin
    int               cyc;
    logic [W-1:0]     ai;
    logic [W-1:0]     bi;
    logic [2*W-1:0]   exp;

    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);

    do_op("ffff_x_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    do_op("b_zero", 16'h1234, 16'h0000, 1'b0, 32'h00000000);
    do_op("a_one", 16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD);
    do_op("u_ffff_x2", 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);

    // Backpressure: DONE must hold for 10 cycles
    start_op(16'h0003, 16'h0005, 1'b0);
    wait_done(cyc);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_prod", 64'(product), 64'd15);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    release_out();
    $display("[TB] op stall product=%h", product);

    // New operands offered while BUSY are ignored
    start_op(16'h0100, 16'h0200, 1'b0);
    step();
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    check("ign_in_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    wait_done(cyc);
    check("ign_prod", 64'(product), 64'h00020000);
    release_out();
    step();
    check("ign_no_queue", 64'(busy), 64'd0);
    $display("[TB] op busy_ignore product=%h", product);

    // Reset in the middle of BUSY (count=2)
    start_op(16'h0007, 16'h0009, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    do_op("after_rst", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF);

`ifdef SIGNED_EN
    do_op("s_m1_x_m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    do_op("s_min_x_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    do_op("s_m1_x_2", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
`endif

    // DIGIT sweep: all instances accept together, then compared with a*b
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ai = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h8001 : W'($urandom);
      bi = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h7FFF : W'($urandom);
      exp = {16'h0000, ai} * {16'h0000, bi};
      a = ai;
      b = bi;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (17) step();
      check("sweep_d4", 64'(product), 64'(exp));
      check("sweep_valid", 64'(sw_valid), 64'hF);
      for (int k = 0; k < 4; k++) check("sweep_dk", 64'(sw_prod[k]), 64'(exp));
      release_out();
      check("sweep_idle", 64'(sw_ready), 64'hF);
      $display("[TB] sweep a=%h b=%h expected=%h", ai, bi, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
